// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and queued-write entry type for the GRF write arbiter
package wb_pkg;

    localparam int WB_DEPTH = 2;
    localparam int WB_AW    = 5;
    localparam int WB_DW    = 32;

    typedef struct packed {
        logic             valid;
        logic [WB_AW-1:0] a3;
        logic [WB_DW-1:0] wd;
        logic [31:0]      pc;
    } wb_entry_t;

    function automatic logic [31:0] wb_onehot(input logic [WB_AW-1:0] a3);
        return 32'(1) << a3;
    endfunction

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// rtl/wb_write_arbiter_fifo.sv - auxiliary write queue (wb_fifo) with cancel-by-address and pending mask
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    input  logic                       cancel_en,
    input  logic [WB_AW-1:0]           cancel_a3,
    output wb_entry_t                  head_entry,
    output logic                       empty,
    output logic                       full,
    output logic [31:0]                pending_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    wb_entry_t         mem_q [DEPTH];
    wb_entry_t         mem_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign head_entry = mem_q[head_q];

    // Popped slots are invalidated so pending_mask can simply OR every slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (pop) begin
            mem_d[head_q].valid = 1'b0;
        end
        if (push) begin
            mem_d[tail_q] = push_entry;
        end
        if (cancel_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_d[i].a3 == cancel_a3) begin
                    mem_d[i].valid = 1'b0;
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].valid) begin
                pending_mask = pending_mask | wb_onehot(mem_q[i].a3);
            end
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges pipeline writeback and queued auxiliary results onto the GRF write port
// Optional write trace printout enabled by defining WB_TRACE_EN.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_a3,
    input  logic [DW-1:0] pipe_wd,
    input  logic [31:0]   pipe_pc,
    input  logic          aux_valid,
    output logic          aux_ready,
    input  logic [AW-1:0] aux_a3,
    input  logic [DW-1:0] aux_wd,
    input  logic [31:0]   aux_pc,
    output logic          grf_we,
    output logic [AW-1:0] grf_a3,
    output logic [DW-1:0] grf_wd,
    output logic [31:0]   grf_pc,
    output logic [31:0]   pending_mask
);

    logic      pipe_live;
    logic      push;
    logic      pop;
    logic      empty;
    logic      full;
    wb_entry_t push_entry;
    wb_entry_t head_entry;
    logic [31:0] fifo_mask;

    assign pipe_live = pipe_we && (pipe_a3 != '0);
    assign aux_ready = !reset && !full;
    assign push      = aux_valid && aux_ready;
    assign pop       = !reset && !pipe_live && !empty;

    // Register 0 is never written, so such entries are stored already invalid.
    always_comb begin
        push_entry.valid = (aux_a3 != '0);
        push_entry.a3    = aux_a3;
        push_entry.wd    = aux_wd;
        push_entry.pc    = aux_pc;
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_entry   (push_entry),
        .pop          (pop),
        .cancel_en    (pipe_live && !reset),
        .cancel_a3    (pipe_a3),
        .head_entry   (head_entry),
        .empty        (empty),
        .full         (full),
        .pending_mask (fifo_mask)
    );

    assign pending_mask = reset ? '0 : fifo_mask;

    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        if (!reset) begin
            if (pipe_live) begin
                grf_we = 1'b1;
                grf_a3 = pipe_a3;
                grf_wd = pipe_wd;
                grf_pc = pipe_pc;
            end else if (!empty && head_entry.valid) begin
                grf_we = 1'b1;
                grf_a3 = head_entry.a3;
                grf_wd = head_entry.wd;
                grf_pc = head_entry.pc;
            end
        end
    end

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && grf_we) begin
            $display("%0d@%08h: $%0d <= %08h", $time, grf_pc, grf_a3, grf_wd);
        end
    end
`else
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - randomized and directed checks of wb_write_arbiter against a queue model
module tb_wb_write_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_a3;
    logic [31:0] aux_wd;
    logic [31:0] aux_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [31:0] pending_mask;

    always #5 clk = ~clk;

    wb_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_we      (pipe_we),
        .pipe_a3      (pipe_a3),
        .pipe_wd      (pipe_wd),
        .pipe_pc      (pipe_pc),
        .aux_valid    (aux_valid),
        .aux_ready    (aux_ready),
        .aux_a3       (aux_a3),
        .aux_wd       (aux_wd),
        .aux_pc       (aux_pc),
        .grf_we       (grf_we),
        .grf_a3       (grf_a3),
        .grf_wd       (grf_wd),
        .grf_pc       (grf_pc),
        .pending_mask (pending_mask)
    );

    typedef struct {
        bit          v;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic        obs_we;
    logic        obs_ready;
    logic [4:0]  obs_a3;
    logic [31:0] obs_wd;
    logic [31:0] obs_mask;

    // Every GRF write the design makes, in order, for the wrap test.
    logic [31:0] commit_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit pwe, input logic [4:0] pa3, input logic [31:0] pwd,
                        input bit av, input logic [4:0] aa3, input logic [31:0] awd);
        bit          live;
        bit          e_we;
        bit          e_rdy;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [31:0] e_pc;
        logic [31:0] e_mask;
        ent_t        e;
        reset     = rst;
        pipe_we   = pwe;
        pipe_a3   = pa3;
        pipe_wd   = pwd;
        pipe_pc   = $urandom;
        aux_valid = av;
        aux_a3    = aa3;
        aux_wd    = awd;
        aux_pc    = $urandom;
        @(negedge clk);

        live   = pwe && (pa3 != 0);
        e_we   = 0;
        e_a3   = 0;
        e_wd   = 0;
        e_pc   = 0;
        e_mask = 0;
        e_rdy  = !rst && (q.size() < DEPTH);
        if (!rst) begin
            foreach (q[i]) if (q[i].v) e_mask[q[i].a3] = 1'b1;
            if (live) begin
                e_we = 1; e_a3 = pa3; e_wd = pwd; e_pc = pipe_pc;
            end else if (q.size() > 0 && q[0].v) begin
                e_we = 1; e_a3 = q[0].a3; e_wd = q[0].wd; e_pc = q[0].pc;
            end
        end
        obs_we = grf_we; obs_a3 = grf_a3; obs_wd = grf_wd; obs_ready = aux_ready; obs_mask = pending_mask;
        if (grf_we === 1'b1) commit_log.push_back(grf_wd);
        check("grf_we", 32'(grf_we), 32'(e_we));
        check("grf_a3", 32'(grf_a3), 32'(e_a3));
        check("grf_wd", grf_wd, e_wd);
        check("grf_pc", grf_pc, e_pc);
        check("aux_ready", 32'(aux_ready), 32'(e_rdy));
        check("pending_mask", pending_mask, e_mask);

        if (rst) begin
            q.delete();
        end else begin
            if (!live && q.size() > 0) void'(q.pop_front());
            if (av && e_rdy) begin
                e.v = (aa3 != 0); e.a3 = aa3; e.wd = awd; e.pc = aux_pc;
                q.push_back(e);
            end
            if (live) foreach (q[i]) if (q[i].a3 == pa3) q[i].v = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        step(1, 1, 5, 32'h5, 1, 6, 32'h6);
        check("rst_we", 32'(obs_we), 0);
        check("rst_ready", 32'(obs_ready), 0);
        step(1, 0, 0, 0, 0, 0, 0);

        step(0, 1, 5, 32'h1234, 0, 0, 0);
        check("pipe_we", 32'(obs_we), 1);
        check("pipe_wd", obs_wd, 32'h1234);
        step(0, 1, 0, 32'h9999, 0, 0, 0);
        check("pipe_a3_zero", 32'(obs_we), 0);

        step(0, 0, 0, 0, 1, 8, 32'hAA);
        check("aux_ready", 32'(obs_ready), 1);
        idle();
        check("aux_commit_wd", obs_wd, 32'hAA);
        check("aux_mask8", obs_mask, 32'h100);
        idle();
        check("aux_mask_clear", obs_mask, 0);

        step(0, 1, 1, 32'h101, 1, 3, 32'h33);
        step(0, 1, 2, 32'h102, 1, 4, 32'h44);
        step(0, 1, 1, 32'h103, 1, 6, 32'h66);
        check("full_ready", 32'(obs_ready), 0);
        check("full_mask", obs_mask, 32'h18);
        idle();
        check("order_first", obs_wd, 32'h33);
        idle();
        check("order_second", obs_wd, 32'h44);

        step(0, 0, 0, 0, 1, 7, 32'h11);
        step(0, 1, 7, 32'h22, 0, 0, 0);
        check("cancel_pipe", obs_wd, 32'h22);
        idle();
        check("cancel_bubble", 32'(obs_we), 0);
        step(0, 1, 9, 32'h99, 1, 9, 32'h98);
        idle();
        check("same_cycle_cancel", 32'(obs_we), 0);

        step(0, 0, 0, 0, 1, 10, 32'hA0);
        step(0, 1, 1, 32'h1, 1, 11, 32'hB0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("midrst_mask", obs_mask, 0);
        check("midrst_we", 32'(obs_we), 0);
        idle();
        check("midrst_gone", 32'(obs_we), 0);

        commit_log.delete();
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 1, 5'(12 + i), 32'hC00 + 32'(i));
            idle();
        end
        check("wrap_count", 32'(commit_log.size()), 6);
        for (int i = 0; i < 6 && i < commit_log.size(); i++)
            check("wrap_data", commit_log[i], 32'hC00 + 32'(i));

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                 $urandom, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-side front end of the general register file. It merges two producers into the single GRF write port.
- Producer 1 is the W-stage pipeline writeback. It has priority and never stalls.
- Producer 2 is an auxiliary multi-cycle producer, such as the MDU or a late load. It uses a valid/ready handshake and is buffered in a small FIFO.
- Exports a pending-write bitmask so the D-stage hazard unit can stall readers of registers whose writes are still queued.

Parameters:
- DEPTH, 2, auxiliary FIFO entries (power of two, 2..8)
- DW, 32, data width
- AW, 5, register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pipe_we  in  1  pipeline W-stage write enable
- pipe_a3  in  AW  pipeline destination register
- pipe_wd  in  DW  pipeline write data
- pipe_pc  in  32  pipeline instruction PC
- aux_valid  in  1  auxiliary result valid
- aux_ready  out  1  auxiliary result accepted this cycle
- aux_a3  in  AW  auxiliary destination register
- aux_wd  in  DW  auxiliary write data
- aux_pc  in  32  auxiliary instruction PC
- grf_we  out  1  GRF write enable
- grf_a3  out  AW  GRF write address
- grf_wd  out  DW  GRF write data
- grf_pc  out  32  PC of the committed write (trace only)
- pending_mask  out  32  bit r set if a live queued write targets register r

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset effects:
  - FIFO is emptied and all entries are invalidated.
  - While reset is high: grf_we=0, aux_ready=0, pending_mask=0, grf_a3/grf_wd/grf_pc=0.
  - A reset mid-operation discards all queued writes.
- Pipeline path:
  - A pipe write is live when pipe_we=1 and pipe_a3!=0.
  - A live pipe write drives grf_* combinationally in the same cycle (zero latency).
  - When pipe_a3=0 the pipe write is dropped. It does not block the FIFO.
- Auxiliary accept:
  - aux_ready = !reset && count<DEPTH. It depends only on registered count, never on aux_valid.
  - A transfer happens when aux_valid && aux_ready. The entry is pushed at the posedge.
  - aux_a3=0 is accepted and stored as invalid (never written).
  - Entries are enqueued in arrival order.
- Drain:
  - When no live pipe write is present and the FIFO is non-empty, the head is popped at the posedge.
  - If the head is valid, grf_we=1 with the head's a3/wd/pc during that cycle.
  - If the head is invalid, it pops with grf_we=0 (bubble).
  - A live pipe write blocks the drain for that cycle.
- Ordering / cancellation:
  - A live pipe write to register r is younger than every queued entry and every same-cycle aux transfer.
  - At that posedge, every entry with a3==r, including one pushed in the same cycle, is invalidated.
- Minimum aux-to-GRF latency: 1 cycle, i.e. push at edge N, write during cycle N+1 if pipe is idle.
- Full FIFO: aux_ready=0. A pop in the same cycle does not allow a push; the push waits one cycle.
- Empty FIFO with no pipe write: grf_we=0.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- pending_mask = OR over valid entries of one-hot(a3). Bit 0 is always 0.
  - Registered view: it reflects FIFO contents after the last edge.
  - It excludes the same-cycle aux input.

Optional Feature:
- Macro WB_TRACE_EN.
- When defined: on every posedge with grf_we=1 and reset=0, the block prints a line of the form "time@pc: $reg <= data".
  - time is $time in decimal.
  - pc is grf_pc in 8-digit hex.
  - reg is grf_a3 in decimal.
  - data is grf_wd in 8-digit hex.
- When undefined: no trace code is compiled. Port list and functional behaviour are identical.

Decomposition:
- Shared package wb_pkg holds:
  - constants WB_DEPTH, WB_AW, WB_DW
  - entry typedef wb_entry_t {valid, a3, wd, pc}
- One sub-module, wb_fifo. It contains the entry array, head/tail/count, push/pop, the per-entry cancel-by-address compare and the pending_mask reduction.
- wb_write_arbiter keeps the priority mux and the handshake.

Test Plan:
- Pipe only: pipe_we=1, a3=5, wd=0x1234 -> grf_we=1, grf_a3=5, grf_wd=0x1234 same cycle. With a3=0 -> grf_we=0.
- Aux single:
  - aux a3=8, wd=0xAA, pipe idle -> aux_ready=1.
  - Next cycle: grf_we=1, a3=8, wd=0xAA, and pending_mask bit8=1.
  - Following cycle: pending_mask=0.
- Backpressure:
  - Push 2 aux writes (a3=3,4) while pipe writes every cycle -> aux_ready=0 on the 3rd cycle; both remain queued.
  - Once the pipe goes idle, writes commit in order 3 then 4.
- Cancellation:
  - Queue aux a3=7 wd=0x11, then pipe write a3=7 wd=0x22 -> entry invalidated.
  - Only the 0x22 write is seen; the later head pop gives grf_we=0.
  - Same-cycle aux+pipe to a3=9 -> only the pipe write commits.
- Reset mid-op: with 2 entries queued, assert reset for 1 cycle -> grf_we=0, aux_ready=0, pending_mask=0; queued writes never appear.
- Wrap: DEPTH=2, 6 consecutive aux writes interleaved with single pipe-idle cycles -> all 6 commit in order with correct data across pointer wrap.
